// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
//   ADD_WIDTH_DEF / ADD_STAGES_DEF : default operand width and pipeline depth
//   add_mode_e                     : add/subtract mode encoding carried on 'sub'
//   full_add                       : the team's one-bit full-adder cell, {cout, s}
package adder_pkg;

  localparam int ADD_WIDTH_DEF  = 16;
  localparam int ADD_STAGES_DEF = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } add_mode_e;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// W-bit combinational ripple-carry slice built from the full-adder cell.
//   a, b : slice operands (b already inverted by the caller for subtract)
//   cin  : carry into bit 0
//   s    : slice sum
//   cout : carry out of the slice MSB
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
  end

  assign cout = c[W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operands split into STAGES slices,
// one slice added per stage with the carry registered between stages.
// Valid/ready handshake on both sides; one global advance stalls everything.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready depends only on output side)
//   a, b, cin, sub      : operands, carry in, mode (sub=1 -> a - b, cin ignored)
//   out_valid, out_ready: output handshake
//   s, cout, ovf, zero  : result, carry out, signed overflow, result-is-zero
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH_DEF,
  parameter int STAGES = ADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int W = WIDTH / STAGES;

  logic             advance;
  add_mode_e        mode;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign mode    = add_mode_e'(sub);
  assign b_eff   = (mode == MODE_SUB) ? ~b : b;
  assign cin_eff = (mode == MODE_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W;       // first bit of the slice added here
    localparam int BW = WIDTH - LO;  // B' bits not yet consumed

    // x_i carries completed sum bits below LO and untouched A bits from LO up,
    // so the same vector serves as the A delay line and the low-sum realigner.
    logic [WIDTH-1:0] x_i;
    logic [BW-1:0]    b_i;
    logic             c_i;
    logic             v_i;
    logic [W-1:0]     s_sl;
    logic             c_sl;
    logic [WIDTH-1:0] x_n;

    if (k == 0) begin : g_src
      assign x_i = a;
      assign b_i = b_eff;
      assign c_i = cin_eff;
      assign v_i = in_valid;
    end else begin : g_src
      assign x_i = g_st[k-1].g_reg.x_p;
      assign b_i = g_st[k-1].g_reg.b_p;
      assign c_i = g_st[k-1].g_reg.c_p;
      assign v_i = g_st[k-1].g_reg.vld_p;
    end

    adder_slice #(
      .W (W)
    ) u_slice (
      .a    (x_i[LO +: W]),
      .b    (b_i[W-1:0]),
      .cin  (c_i),
      .s    (s_sl),
      .cout (c_sl)
    );

    always_comb begin
      x_n          = x_i;
      x_n[LO +: W] = s_sl;
    end

    if (k == STAGES - 1) begin : g_out
      // ---- final stage boundary: output register ----
      // Bubbles leave the held result untouched; only out_valid follows them.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          s         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          out_valid <= v_i;
          if (v_i) begin
            s    <= x_n;
            cout <= c_sl;
            ovf  <= (x_i[WIDTH-1] == b_i[W-1]) && (x_n[WIDTH-1] != x_i[WIDTH-1]);
            zero <= (x_n == '0);
          end
        end
      end
    end else begin : g_reg
      logic [WIDTH-1:0] x_p;
      logic [BW-W-1:0]  b_p;
      logic             c_p;
      logic             vld_p;

      // ---- stage k boundary: carry, partial sum and skewed operands ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= 1'b0;
        end else if (advance) begin
          vld_p <= v_i;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          x_p <= x_n;
          b_p <= b_i[BW-1:W];
          c_p <= c_sl;
        end
      end
    end
  end

endmodule
